// File: rtl/icache_line_fill.sv
// Instruction-cache line fill: on a miss, reads four 32-bit beats and presents one 128-bit line.
// Miss-to-valid is 5 cycles with zero-wait memory, plus 1 per stall; mem_req holds until mem_ack.
module icache_line_fill #(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              imiss,
  input  logic [ADDR_W-1:0] imiss_addr,
  input  logic              iflush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [127:0]      oline,
  output logic [ADDR_W-1:0] oline_addr,
  output logic              oline_valid,
  output logic              obusy
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] beat;
  logic       squash;
  logic       last_ack;
  logic       unused_addr_bits;

  // The byte offset within the line never reaches memory.
  assign unused_addr_bits = ^imiss_addr[3:0];
  assign last_ack         = mem_ack && (beat == 2'(BEATS-1));

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    oline_valid = 1'b0;
    obusy       = 1'b1;
    case (state)
      IDLE: begin
        obusy = 1'b0;
        if (imiss) state_nxt = FILL;
      end
      FILL: begin
        if (last_ack) state_nxt = DONE;
      end
      DONE: begin
        // A redirect arriving in the presentation cycle still kills the line.
        oline_valid = ~squash & ~iflush;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      beat       <= 2'd0;
      squash     <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      oline      <= '0;
      oline_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imiss) begin
            oline_addr <= {imiss_addr[ADDR_W-1:4], 4'b0000};
            mem_addr   <= {imiss_addr[ADDR_W-1:4], 4'b0000};
            mem_req    <= 1'b1;
            beat       <= 2'd0;
            squash     <= 1'b0;
          end
        end
        FILL: begin
          // Memory cannot cancel, so a flush only marks the line for discard.
          if (iflush) squash <= 1'b1;
          if (mem_ack) begin
            oline[32*beat +: 32] <= mem_rdata;
            if (last_ack) begin
              mem_req <= 1'b0;
            end else begin
              beat     <= beat + 2'd1;
              mem_addr <= {oline_addr[ADDR_W-1:4], beat + 2'd1, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Randomized scoreboard bench for icache_line_fill: a memory responder checks request addresses,
// and a monitor compares every presented line against lines predicted when each miss is issued.
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         rstn;
  logic         imiss;
  logic [31:0]  imiss_addr;
  logic         iflush;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic [127:0] oline;
  logic [31:0]  oline_addr;
  logic         oline_valid;
  logic         obusy;

  int checks = 0;
  int failures = 0;
  bit stray_ack = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
  } beat_t;

  typedef struct {
    logic [127:0] line;
    logic [31:0]  addr;
  } line_t;

  beat_t beat_q[$];
  line_t exp_q[$];

  always #5 clk = ~clk;

  icache_line_fill #(.BEATS(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imiss      (imiss),
    .imiss_addr (imiss_addr),
    .iflush     (iflush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .oline      (oline),
    .oline_addr (oline_addr),
    .oline_valid(oline_valid),
    .obusy      (obusy)
  );

  function automatic void check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic void check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Memory responder: serves the predicted beats in order, stalling as each beat asks.
  always @(posedge clk) begin
    beat_t b;
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (beat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req actual mem_addr=%h required no request", mem_addr);
      end else begin
        b = beat_q.pop_front();
        if (b.waits > 0) begin
          check_v("mem_addr_hold", 128'(mem_addr), 128'(b.addr));
          b.waits = b.waits - 1;
          beat_q.push_front(b);
        end else begin
          check_v("mem_addr", 128'(mem_addr), 128'(b.addr));
          mem_ack   = 1'b1;
          mem_rdata = b.data;
        end
      end
    end else if (stray_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end
  end

  // Monitor: every valid line must match the oldest predicted unsquashed fill.
  always @(negedge clk) begin
    line_t e;
    if (oline_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual oline_addr=%h required no line", oline_addr);
      end else begin
        e = exp_q.pop_front();
        check_v("oline", oline, e.line);
        check_v("oline_addr", 128'(oline_addr), 128'(e.addr));
      end
    end
  end

  // Reference model: a miss yields four word reads of the aligned line, assembled low word first.
  task automatic push_fill(input logic [31:0] addr, input bit squashed, input bit fixed, input int w[4]);
    beat_t        b;
    line_t        e;
    logic [31:0]  base = addr & 32'hFFFF_FFF0;
    logic [127:0] line = '0;
    for (int k = 0; k < 4; k++) begin
      b.addr  = base + 32'(4 * k);
      b.data  = fixed ? 32'(32'hA0 + k) : $urandom;
      b.waits = w[k];
      beat_q.push_back(b);
      line = line | ({96'b0, b.data} << (32 * k));
    end
    if (!squashed) begin
      e.line = line;
      e.addr = base;
      exp_q.push_back(e);
    end
  endtask

  // flush_at: -1 none, 0..3 during that beat, 4 during the presentation cycle.
  task automatic run_fill(input logic [31:0] addr, input int flush_at, input int wait_beat,
                          input int wait_n, input bit rnd, input bit noise, input bit fixed);
    int          w[4];
    int          total = 0;
    int          n;
    int          valid_at = -1;
    int          idle_at = -1;
    bit          squashed = (flush_at >= 0);
    logic [31:0] noise_addr = addr ^ 32'h0000_4440;
    for (int k = 0; k < 4; k++) begin
      w[k] = rnd ? int'($urandom_range(0, 2)) : ((k == wait_beat) ? wait_n : 0);
      total += w[k];
    end
    push_fill(addr, squashed, fixed, w);
    imiss      = 1'b1;
    imiss_addr = addr;
    @(posedge clk); #2;
    n = 1;
    while (idle_at < 0 && n < 100) begin
      imiss      = noise && mem_req;
      imiss_addr = noise ? noise_addr : addr;
      iflush     = (flush_at >= 0 && flush_at < 4 && mem_req && int'(mem_addr[3:2]) == flush_at) ||
                   (flush_at == 4 && obusy && !mem_req);
      @(negedge clk);
      if (n == 1) check_i("busy_after_miss", int'(obusy), 1);
      if (oline_valid && valid_at < 0) valid_at = n;
      if (!obusy) idle_at = n;
      @(posedge clk); #2;
      n++;
    end
    imiss  = 1'b0;
    iflush = 1'b0;
    check_i("idle_cycle", idle_at, 6 + total);
    check_i("valid_cycle", valid_at, squashed ? -1 : 5 + total);
    check_i("beats_left", beat_q.size(), 0);
  endtask

  initial begin
    int zw[4] = '{0, 0, 0, 0};
    int n;
    int v1;
    int v2;
    bit found;

    rstn = 1'b1;
    imiss = 1'b0;
    imiss_addr = '0;
    iflush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_i("rst_mem_req", int'(mem_req), 0);
    check_i("rst_obusy", int'(obusy), 0);
    check_i("rst_valid", int'(oline_valid), 0);
    check_v("rst_mem_addr", 128'(mem_addr), 128'h0);
    check_v("rst_oline", oline, 128'h0);
    check_v("rst_oline_addr", 128'(oline_addr), 128'h0);
    rstn = 1'b0;
    @(posedge clk); #2;

    run_fill(32'h0000_1238, -1, -1, 0, 1'b0, 1'b0, 1'b1);
    check_v("zw_oline", oline, 128'h000000A3_000000A2_000000A1_000000A0);
    check_v("zw_oline_addr", 128'(oline_addr), 128'h1230);

    run_fill(32'h0000_1234, -1, 1, 3, 1'b0, 1'b0, 1'b0);
    run_fill(32'h0000_5678, 2, -1, 0, 1'b0, 1'b0, 1'b0);
    run_fill(32'h0000_9ABC, 3, -1, 0, 1'b0, 1'b0, 1'b0);
    run_fill(32'h0000_DEF0, 4, -1, 0, 1'b0, 1'b0, 1'b0);
    run_fill(32'h0000_2220, -1, -1, 0, 1'b0, 1'b1, 1'b0);

    // Reset while beat 1 is outstanding.
    push_fill(32'h0000_3000, 1'b1, 1'b0, zw);
    imiss = 1'b1;
    imiss_addr = 32'h0000_3000;
    @(posedge clk); #2;
    imiss = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && mem_addr[3:2] == 2'd1) found = 1'b1;
      else begin
        @(posedge clk); #2;
      end
    end
    check_i("rst_reached_beat1", int'(found), 1);
    rstn = 1'b1;
    @(posedge clk); #2;
    rstn = 1'b0;
    beat_q.delete();
    check_i("midrst_mem_req", int'(mem_req), 0);
    check_i("midrst_obusy", int'(obusy), 0);
    check_v("midrst_oline", oline, 128'h0);
    check_v("midrst_oline_addr", 128'(oline_addr), 128'h0);
    stray_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
    end
    stray_ack = 1'b0;
    check_i("stray_obusy", int'(obusy), 0);
    check_i("stray_mem_req", int'(mem_req), 0);
    check_v("stray_oline", oline, 128'h0);
    run_fill(32'h0000_3004, -1, -1, 0, 1'b0, 1'b0, 1'b0);

    // Back-to-back misses, second at the top of the address space.
    push_fill(32'h0000_0100, 1'b0, 1'b0, zw);
    push_fill(32'hFFFF_FFF4, 1'b0, 1'b0, zw);
    imiss = 1'b1;
    imiss_addr = 32'h0000_0100;
    @(posedge clk); #2;
    imiss_addr = 32'hFFFF_FFF4;
    v1 = -1;
    v2 = -1;
    n = 1;
    while (n < 40 && v2 < 0) begin
      if (mem_req && mem_addr[31:4] == 28'hFFF_FFFF) imiss = 1'b0;
      @(negedge clk);
      if (oline_valid) begin
        if (v1 < 0) v1 = n;
        else if (v2 < 0) v2 = n;
      end
      @(posedge clk); #2;
      n++;
    end
    imiss = 1'b0;
    check_i("b2b_first_valid", v1, 5);
    check_i("b2b_second_valid", v2, 11);
    check_i("b2b_beats_left", beat_q.size(), 0);
    check_i("b2b_obusy", int'(obusy), 0);

    for (int i = 0; i < 12; i++) begin
      run_fill($urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
               -1, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    check_i("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
